// File: rtl/cpc_ram_pkg.sv
// Shared types for the CPC RAM-expansion banker: block schemes, FSM states and the
// port-select tag carried in data[7:6] of a bank-configuration write.
package cpc_ram_pkg;

  typedef enum logic [2:0] {C0, C1, C2, C3, C4, C5, C6, C7} scheme_t;

  typedef enum logic [1:0] {IO_IDLE, IO_HELD, IO_COMMIT} io_state_t;

  typedef enum logic {M_IDLE, M_ACT} mem_state_t;

  localparam logic [1:0] PORT_SEL_DATA = 2'b11;

endpackage

// File: rtl/cpc_ram_banker_decode.sv
// Combinational scheme/page decode: SRAM select, upper SRAM address and the A15/A14
// overdrive request for the current access.
module cpc_ram_decode
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS   = 3,
  parameter int MODE464     = 1,
  parameter int SHADOW_BANK = 7
) (
  input  scheme_t              scheme,
  input  logic [1:0]           page,
  input  logic [BANK_BITS-1:0] bank,
  output logic                 ramcs_b_r,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic                 od_a15,
  output logic                 od_a15_val,
  output logic                 od_a14
);

  localparam logic [BANK_BITS-1:0] SHADOW   = BANK_BITS'(SHADOW_BANK);
  // "Internal" pages hit the shadow bank when the expansion provides the base 64K.
  localparam logic                 INT_CS_B = (MODE464 == 0);

  always_comb begin
    ramcs_b_r  = INT_CS_B;
    ramadrhi   = {SHADOW, page};
    od_a15     = 1'b0;
    od_a15_val = 1'b0;
    od_a14     = 1'b0;
    case (scheme)
      C0: ;
      C1: begin
        if (page == 2'd3) begin
          ramcs_b_r = 1'b0;
          ramadrhi  = {bank, 2'd3};
          od_a15    = 1'b1;
          od_a14    = 1'b1;
        end
      end
      C2: begin
        ramcs_b_r = 1'b0;
        ramadrhi  = {bank, page};
        od_a15    = 1'b1;
        od_a14    = 1'b1;
      end
      C3: begin
        if (page == 2'd3) begin
          ramcs_b_r = 1'b0;
          ramadrhi  = {bank, 2'd3};
          od_a15    = 1'b1;
          od_a14    = 1'b1;
        end else if (page == 2'd1) begin
          // Page 1 shows internal page 3; A15 is pulled high so base RAM agrees.
          ramadrhi   = {SHADOW, 2'd3};
          od_a15     = 1'b1;
          od_a15_val = 1'b1;
        end
      end
      default: begin
        if (page == 2'd1) begin
          ramcs_b_r = 1'b0;
          ramadrhi  = {bank, scheme[1:0]};
          od_a15    = 1'b1;
          od_a14    = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/cpc_ram_banker.sv
// CPC RAM-expansion bank controller: captures &7Fxx bank writes (commit two clocks after
// IORQ ends, deferred while MREQ is low) and decodes each memory access onto the SRAM.
module cpc_ram_banker
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS   = 3,
  parameter int MODE464     = 1,
  parameter int SHADOW_BANK = 7,
  parameter int OVERDRIVE   = 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 iorq_b,
  input  logic                 mreq_b,
  input  logic                 wr_b,
  input  logic                 ramrd_b,
  input  logic                 adr15,
  input  logic                 adr14,
  input  logic [2:0]           adr_port,
  input  logic [7:0]           data,
  output logic                 ramcs_b,
  output logic                 ramoe_b,
  output logic                 ramwe_b,
  output logic                 ramdis,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic                 a15_oe,
  output logic                 a15_val,
  output logic                 a14_oe,
  output logic [BANK_BITS+2:0] bank_cfg
);

  localparam logic [BANK_BITS-1:0] SHADOW       = BANK_BITS'(SHADOW_BANK);
  localparam logic [BANK_BITS-1:0] SHADOW_ALIAS = {SHADOW[BANK_BITS-1:1], 1'b0};
  localparam logic                 ALIAS_EN     = (MODE464 != 0);
  localparam logic                 OD_EN        = (OVERDRIVE != 0);

  io_state_t            io_state;
  mem_state_t           m_state;
  logic [BANK_BITS+2:0] pending;
  logic [BANK_BITS+2:0] port_word;
  logic [1:0]           page_lat;
  logic [1:0]           page_sel;
  logic [BANK_BITS-1:0] cfg_bank;
  logic [BANK_BITS-1:0] bank_eff;
  logic                 port_hit;
  logic                 dec_cs_b_r;
  logic [BANK_BITS+1:0] dec_adrhi;
  logic                 dec_od_a15;
  logic                 dec_od_a15_val;
  logic                 dec_od_a14;
  logic                 unused_adr_port;

  assign unused_adr_port = ^adr_port;

  if (BANK_BITS > 3) begin : g_ext_bank
    assign port_word = {adr_port[BANK_BITS-4:0], data[5:0]};
  end else begin : g_base_bank
    assign port_word = data[5:0];
  end

  assign port_hit = !iorq_b && !wr_b && !adr15 && (data[7:6] == PORT_SEL_DATA);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      io_state <= IO_IDLE;
      pending  <= '0;
      bank_cfg <= '0;
    end else begin
      case (io_state)
        IO_IDLE: begin
          if (port_hit) begin
            pending  <= port_word;
            io_state <= IO_HELD;
          end
        end
        IO_HELD: if (iorq_b) io_state <= IO_COMMIT;
        IO_COMMIT: begin
          // Never remap underneath an access in flight.
          if (mreq_b) begin
            bank_cfg <= pending;
            io_state <= IO_IDLE;
          end
        end
        default: io_state <= IO_IDLE;
      endcase
    end
  end

  // Latched page keeps the mapping stable once we start overdriving A15/A14.
  assign page_sel = (m_state == M_ACT) ? page_lat : {adr15, adr14};
  assign cfg_bank = bank_cfg[BANK_BITS+2:3];
  assign bank_eff = (ALIAS_EN && cfg_bank == SHADOW) ? SHADOW_ALIAS : cfg_bank;

  cpc_ram_decode #(
    .BANK_BITS  (BANK_BITS),
    .MODE464    (MODE464),
    .SHADOW_BANK(SHADOW_BANK)
  ) u_decode (
    .scheme    (scheme_t'(bank_cfg[2:0])),
    .page      (page_sel),
    .bank      (bank_eff),
    .ramcs_b_r (dec_cs_b_r),
    .ramadrhi  (dec_adrhi),
    .od_a15    (dec_od_a15),
    .od_a15_val(dec_od_a15_val),
    .od_a14    (dec_od_a14)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      m_state  <= M_IDLE;
      page_lat <= 2'b00;
      a15_oe   <= 1'b0;
      a15_val  <= 1'b0;
      a14_oe   <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (!mreq_b) begin
            m_state  <= M_ACT;
            page_lat <= {adr15, adr14};
            a15_oe   <= OD_EN && dec_od_a15;
            a15_val  <= OD_EN && dec_od_a15_val;
            a14_oe   <= OD_EN && dec_od_a14;
          end
        end
        M_ACT: begin
          if (mreq_b) begin
            m_state <= M_IDLE;
            a15_oe  <= 1'b0;
            a15_val <= 1'b0;
            a14_oe  <= 1'b0;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  assign ramcs_b  = !reset_b || dec_cs_b_r || mreq_b;
  assign ramdis   = reset_b ? !dec_cs_b_r : ALIAS_EN;
  assign ramadrhi = reset_b ? dec_adrhi : '0;
  assign ramoe_b  = ramrd_b;
  assign ramwe_b  = wr_b;

endmodule
